// File: rtl/str_nat_conv.sv
// RX AXI4-Stream slave to native Pkt_ framing (SOF/EOF/BC) with TKEEP and frame-length checks.
// Optional macro STR_NAT_STATS_EN adds saturating FRM_CNT / ERR_CNT outputs.
module str_nat_conv #(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_WORDS  = 512
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] STR_TDATA,
    input  logic [3:0]  STR_TKEEP,
    input  logic        STR_TLAST,
    input  logic        STR_TUSER,
    input  logic        STR_TVALID,
    output logic        STR_TREADY,
    output logic [31:0] Pkt_DATA,
    output logic        Pkt_SOF,
    output logic        Pkt_EOF,
    output logic [1:0]  Pkt_BC,
    output logic        Pkt_ERR,
    output logic        Pkt_VALID,
    input  logic        Pkt_RDY
`ifdef STR_NAT_STATS_EN
    ,
    output logic [15:0] FRM_CNT,
    output logic [15:0] ERR_CNT
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MAX_WORDS) + 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_WORDS);
    localparam logic [CW-1:0] WCNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eof;
        logic [1:0]  bc;
        logic        err;
    } entry_t;

    state_t          state_q;
    logic [CW-1:0]   wcnt_q;
    logic [CW-1:0]   wcnt_d;
    logic            uerr_q;

    entry_t          fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;
    entry_t          out_q;
    logic            out_valid_q;

    logic            tready;
    logic            push;
    logic            pop;
    logic            wr_en;
    logic            load;
    logic            mem_nonempty;
    logic            last_ok;
    logic [1:0]      last_bc;
    logic            keep_err;
    logic            max_hit;
    logic            closes;
    logic            bad_close;
    entry_t          wr_entry;

    // Handshake and FIFO bookkeeping; the count covers the memory plus the output register.
    always_comb begin
        tready       = !RST && (cnt_q != FULL_CNT);
        push         = STR_TVALID && tready;
        pop          = out_valid_q && Pkt_RDY;
        wr_en        = push && (state_q != S_DROP);
        mem_nonempty = (cnt_q != {{AW{1'b0}}, out_valid_q});
        load         = mem_nonempty && (!out_valid_q || Pkt_RDY);
        cnt_d        = cnt_q;
        if (wr_en && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!wr_en && pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_comb begin
        last_ok = 1'b1;
        last_bc = 2'd0;
        case (STR_TKEEP)
            4'b1111: last_bc = 2'd0;
            4'b0111: last_bc = 2'd1;
            4'b0011: last_bc = 2'd2;
            4'b0001: last_bc = 2'd3;
            default: last_ok = 1'b0;
        endcase
    end

    // Beat classification: what this beat would be if written in the current state.
    always_comb begin
        wcnt_d    = (state_q == S_FRAME) ? (wcnt_q + WCNT_ONE) : WCNT_ONE;
        keep_err  = STR_TLAST ? !last_ok : (STR_TKEEP != 4'b1111);
        max_hit   = (wcnt_d == MAX_CNT);
        closes    = STR_TLAST || max_hit || keep_err;
        bad_close = keep_err || (max_hit && !STR_TLAST);

        wr_entry.data = STR_TDATA;
        wr_entry.sof  = (state_q == S_IDLE);
        wr_entry.eof  = closes;
        wr_entry.bc   = (STR_TLAST && !keep_err) ? last_bc : 2'd0;
        wr_entry.err  = closes && (bad_close || uerr_q || STR_TUSER);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            uerr_q  <= 1'b0;
        end else if (push) begin
            case (state_q)
                S_IDLE, S_FRAME: begin
                    wcnt_q <= wcnt_d;
                    if (closes) begin
                        state_q <= STR_TLAST ? S_IDLE : S_DROP;
                        uerr_q  <= 1'b0;
                    end else begin
                        state_q <= S_FRAME;
                        uerr_q  <= uerr_q || STR_TUSER;
                    end
                end
                S_DROP: begin
                    if (STR_TLAST) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q] <= wr_entry;
        end
    end

    // The output register prefetches the memory head so Pkt_ outputs come straight from flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (load) begin
                out_q       <= fifo_mem[rd_ptr_q];
                rd_ptr_q    <= rd_ptr_q + PTR_ONE;
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign STR_TREADY = tready;
    assign Pkt_DATA   = out_q.data;
    assign Pkt_SOF    = out_q.sof;
    assign Pkt_EOF    = out_q.eof;
    assign Pkt_BC     = out_q.bc;
    assign Pkt_ERR    = out_q.err;
    assign Pkt_VALID  = out_valid_q;

`ifdef STR_NAT_STATS_EN
    logic [15:0] frm_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            frm_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (wr_en && wr_entry.eof) begin
            if (frm_cnt_q != 16'hFFFF) begin
                frm_cnt_q <= frm_cnt_q + 16'd1;
            end
            if (wr_entry.err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign FRM_CNT = frm_cnt_q;
    assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_str_nat_conv.sv
// Self-checking bench for str_nat_conv: frame-level reference model, directed cases, random traffic.
`timescale 1ns/1ps
module tb_str_nat_conv;
    localparam int DEPTH = 8;
    localparam int MAXW  = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eof;
        logic [1:0]  bc;
        logic        err;
    } word_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] STR_TDATA = '0;
    logic [3:0]  STR_TKEEP = '0;
    logic        STR_TLAST = 1'b0;
    logic        STR_TUSER = 1'b0;
    logic        STR_TVALID = 1'b0;
    logic        STR_TREADY;
    logic [31:0] Pkt_DATA;
    logic        Pkt_SOF;
    logic        Pkt_EOF;
    logic [1:0]  Pkt_BC;
    logic        Pkt_ERR;
    logic        Pkt_VALID;
    logic        Pkt_RDY = 1'b0;
`ifdef STR_NAT_STATS_EN
    logic [15:0] FRM_CNT;
    logic [15:0] ERR_CNT;
`endif

    int          checks = 0;
    int          errors = 0;
    word_t       exp_q[$];
    int          rdy_mode = 0;
    logic        drv_wr = 1'b0;
    int          acc_total = 0;
    int          mdl_frames = 0;
    int          mdl_errs = 0;
    logic        bg_done = 1'b0;

    logic [31:0] fr_data [16];
    logic [3:0]  fr_keep [16];
    logic        fr_user [16];
    int          fr_n = 0;
    word_t       mdl_w [16];
    int          mdl_n = 0;

    str_nat_conv #(.FIFO_DEPTH(DEPTH), .MAX_WORDS(MAXW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .STR_TDATA  (STR_TDATA),
        .STR_TKEEP  (STR_TKEEP),
        .STR_TLAST  (STR_TLAST),
        .STR_TUSER  (STR_TUSER),
        .STR_TVALID (STR_TVALID),
        .STR_TREADY (STR_TREADY),
        .Pkt_DATA   (Pkt_DATA),
        .Pkt_SOF    (Pkt_SOF),
        .Pkt_EOF    (Pkt_EOF),
        .Pkt_BC     (Pkt_BC),
        .Pkt_ERR    (Pkt_ERR),
        .Pkt_VALID  (Pkt_VALID),
        .Pkt_RDY    (Pkt_RDY)
`ifdef STR_NAT_STATS_EN
        ,
        .FRM_CNT    (FRM_CNT),
        .ERR_CNT    (ERR_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
    always @(posedge CLK) begin
        #1;
        case (rdy_mode)
            0:       Pkt_RDY = 1'b1;
            1:       Pkt_RDY = 1'($urandom_range(1));
            default: Pkt_RDY = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Frame-level reference: walk the beats, stop at the first closing condition.
    function automatic void run_model();
        logic       ue;
        logic       last;
        logic       kerr;
        logic       hit;
        logic [1:0] bc;
        mdl_n = 0;
        ue    = 1'b0;
        for (int i = 0; i < fr_n; i++) begin
            last = (i == fr_n - 1);
            ue   = ue | fr_user[i];
            hit  = (i + 1 == MAXW);
            bc   = 2'd0;
            kerr = 1'b0;
            if (last) begin
                case (fr_keep[i])
                    4'hF:    bc = 2'd0;
                    4'h7:    bc = 2'd1;
                    4'h3:    bc = 2'd2;
                    4'h1:    bc = 2'd3;
                    default: kerr = 1'b1;
                endcase
            end else begin
                kerr = (fr_keep[i] != 4'hF);
            end
            mdl_w[mdl_n].data = fr_data[i];
            mdl_w[mdl_n].sof  = (i == 0);
            mdl_w[mdl_n].eof  = last || hit || kerr;
            mdl_w[mdl_n].bc   = 2'd0;
            mdl_w[mdl_n].err  = 1'b0;
            if (last || hit || kerr) begin
                mdl_w[mdl_n].bc  = bc;
                mdl_w[mdl_n].err = kerr || (hit && !last) || ue;
                mdl_n++;
                break;
            end
            mdl_n++;
        end
    endfunction

    task automatic mk(input int n, input logic [3:0] k_mid, input logic [3:0] k_last);
        fr_n = n;
        for (int i = 0; i < n; i++) begin
            fr_data[i] = $urandom;
            fr_keep[i] = (i == n - 1) ? k_last : k_mid;
            fr_user[i] = 1'b0;
        end
    endtask

    task automatic queue_frame();
        run_model();
        for (int i = 0; i < mdl_n; i++) exp_q.push_back(mdl_w[i]);
        mdl_frames++;
        if (mdl_w[mdl_n-1].err) mdl_errs++;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic u, input logic wr, output int waited);
        logic rdy;
        STR_TDATA  = d;
        STR_TKEEP  = k;
        STR_TLAST  = l;
        STR_TUSER  = u;
        drv_wr     = wr;
        STR_TVALID = 1'b1;
        waited     = 0;
        forever begin
            @(negedge CLK);
            rdy = STR_TREADY;
            @(posedge CLK);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 1000) begin
                checks++;
                errors++;
                $display("FAIL beat_accept_timeout waited=%0d required<=1000", waited);
                break;
            end
        end
        STR_TVALID = 1'b0;
        drv_wr     = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        int w;
        queue_frame();
        for (int i = 0; i < fr_n; i++) begin
            if (gaps && ($urandom_range(3) == 0)) begin
                @(posedge CLK);
                #1;
            end
            send_beat(fr_data[i], fr_keep[i], (i == fr_n - 1), fr_user[i], (i < mdl_n), w);
        end
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        STR_TVALID = 1'b0;
        exp_q.delete();
        mdl_frames = 0;
        mdl_errs   = 0;
        @(posedge CLK);
        @(negedge CLK);
        chk("reset_state", {STR_TREADY, Pkt_VALID, Pkt_SOF, Pkt_EOF, Pkt_BC, Pkt_ERR, Pkt_DATA}, 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < 2000)) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    // Checks every cycle: fill-level vs TREADY, empty vs VALID, stalled head stability, word order/content.
    task automatic monitor();
        int    occ;
        logic  hold_v;
        word_t hold_w;
        word_t got;
        word_t e;
        occ    = 0;
        hold_v = 1'b0;
        hold_w = '0;
        forever begin
            @(negedge CLK);
            got.data = Pkt_DATA;
            got.sof  = Pkt_SOF;
            got.eof  = Pkt_EOF;
            got.bc   = Pkt_EOF ? Pkt_BC : 2'd0;
            got.err  = Pkt_EOF & Pkt_ERR;
            if (RST) begin
                occ    = 0;
                hold_v = 1'b0;
            end else begin
                chk("tready_vs_fill", STR_TREADY, (occ != DEPTH));
                if (occ == 0) chk("valid_when_empty", Pkt_VALID, 0);
                if (hold_v) chk("head_hold", {Pkt_VALID, got}, {1'b1, hold_w});
                if (Pkt_VALID && Pkt_RDY) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word got=%h required=none", got);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", got, e);
                    end
                end
                hold_v = Pkt_VALID && !Pkt_RDY;
                hold_w = got;
                if (STR_TVALID && STR_TREADY && drv_wr) begin
                    occ++;
                    acc_total++;
                end
                if (Pkt_VALID && Pkt_RDY) occ--;
            end
        end
    endtask

    initial begin
        fork
            monitor();
            begin
                int w;
                int n;
                int acc0;
                logic [3:0] good_keep [4];
                good_keep[0] = 4'hF;
                good_keep[1] = 4'h7;
                good_keep[2] = 4'h3;
                good_keep[3] = 4'h1;

                // 3-beat frame, BC=2, with first-word latency
                do_reset();
                rdy_mode = 0;
                mk(3, 4'hF, 4'h3);
                run_model();
                chk("pin3_count", mdl_n, 3);
                chk("pin3_flags", {mdl_w[0].sof, mdl_w[0].eof, mdl_w[2].sof, mdl_w[2].eof, mdl_w[2].bc, mdl_w[2].err},
                    {1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0});
                queue_frame();
                send_beat(fr_data[0], fr_keep[0], 1'b0, 1'b0, 1'b1, w);
                @(negedge CLK);
                chk("lat_not_yet", Pkt_VALID, 0);
                @(posedge CLK);
                #1;
                @(negedge CLK);
                chk("lat_first_word", {Pkt_VALID, Pkt_SOF, Pkt_DATA}, {1'b1, 1'b1, fr_data[0]});
                @(posedge CLK);
                #1;
                send_beat(fr_data[1], fr_keep[1], 1'b0, 1'b0, 1'b1, w);
                send_beat(fr_data[2], fr_keep[2], 1'b1, 1'b0, 1'b1, w);
                drain("drain_t1");

                // back-to-back single-beat frames, TKEEP=0001
                mk(1, 4'hF, 4'h1);
                run_model();
                chk("pin1_flags", {mdl_n[3:0], mdl_w[0].sof, mdl_w[0].eof, mdl_w[0].bc, mdl_w[0].err},
                    {4'd1, 1'b1, 1'b1, 2'd3, 1'b0});
                for (int f = 0; f < 6; f++) begin
                    mk(1, 4'hF, 4'h1);
                    queue_frame();
                    send_beat(fr_data[0], fr_keep[0], 1'b1, 1'b0, 1'b1, w);
                    chk("b2b_no_stall", w, 0);
                end
                drain("drain_t2");

                // TUSER sets ERR on EOF without truncating
                mk(3, 4'hF, 4'h7);
                fr_user[1] = 1'b1;
                run_model();
                chk("pin_user", {mdl_n[3:0], mdl_w[2].eof, mdl_w[2].bc, mdl_w[2].err}, {4'd3, 1'b1, 2'd1, 1'b1});
                send_frame(1'b0);
                drain("drain_user");

                // backpressure: 10 beats offered with the sink stalled
                rdy_mode = 2;
                repeat (2) @(posedge CLK);
                #1;
                acc0    = acc_total;
                bg_done = 1'b0;
                fork
                    begin
                        mk(4, 4'hF, 4'hF);
                        send_frame(1'b0);
                        mk(4, 4'hF, 4'h3);
                        send_frame(1'b0);
                        mk(2, 4'hF, 4'h1);
                        send_frame(1'b0);
                        bg_done = 1'b1;
                    end
                join_none
                repeat (30) @(posedge CLK);
                @(negedge CLK);
                chk("bp_tready_low", STR_TREADY, 0);
                chk("bp_accepted", acc_total - acc0, 8);
                @(posedge CLK);
                #1;
                rdy_mode = 0;
                n = 0;
                while (!bg_done && (n < 2000)) begin
                    @(posedge CLK);
                    #1;
                    n++;
                end
                chk("bp_done", bg_done, 1);
                drain("drain_bp");

                // TKEEP error on beat 2 of 5, then a clean frame
                mk(5, 4'hF, 4'hF);
                fr_keep[1] = 4'h7;
                run_model();
                chk("pin_keep", {mdl_n[3:0], mdl_w[1].sof, mdl_w[1].eof, mdl_w[1].bc, mdl_w[1].err},
                    {4'd2, 1'b0, 1'b1, 2'd0, 1'b1});
                send_frame(1'b0);
                mk(2, 4'hF, 4'h7);
                send_frame(1'b0);
                drain("drain_keep");

                // over-length frame truncated at MAX_WORDS, then an exact-length clean frame
                do_reset();
                mk(6, 4'hF, 4'hF);
                run_model();
                chk("pin_max", {mdl_n[3:0], mdl_w[3].eof, mdl_w[3].err}, {4'd4, 1'b1, 1'b1});
                send_frame(1'b0);
                drain("drain_max");
`ifdef STR_NAT_STATS_EN
                chk("stats_frm_1", FRM_CNT, 1);
                chk("stats_err_1", ERR_CNT, 1);
`endif
                mk(4, 4'hF, 4'h3);
                run_model();
                chk("pin_exact", {mdl_n[3:0], mdl_w[3].eof, mdl_w[3].bc, mdl_w[3].err}, {4'd4, 1'b1, 2'd2, 1'b0});
                send_frame(1'b0);
                drain("drain_exact");

                // reset in the middle of a 4-beat frame
                rdy_mode = 2;
                repeat (2) @(posedge CLK);
                #1;
                mk(4, 4'hF, 4'hF);
                send_beat(fr_data[0], 4'hF, 1'b0, 1'b0, 1'b1, w);
                send_beat(fr_data[1], 4'hF, 1'b0, 1'b0, 1'b1, w);
                repeat (2) @(posedge CLK);
                @(negedge CLK);
                chk("mid_valid", {Pkt_VALID, Pkt_SOF, Pkt_DATA}, {1'b1, 1'b1, fr_data[0]});
                @(posedge CLK);
                #1;
                do_reset();
                @(negedge CLK);
                chk("rst_flush_valid", Pkt_VALID, 0);
                @(posedge CLK);
                #1;
                rdy_mode = 0;
                mk(1, 4'hF, 4'hF);
                send_frame(1'b0);
                drain("drain_rst");

                // randomized traffic with random gaps and random sink ready
                rdy_mode = 1;
                for (int f = 0; f < 40; f++) begin
                    fr_n = int'($urandom_range(1, 7));
                    for (int i = 0; i < fr_n; i++) begin
                        fr_data[i] = $urandom;
                        fr_user[i] = ($urandom_range(15) == 0);
                        if (i == fr_n - 1) begin
                            if ($urandom_range(9) < 8) fr_keep[i] = good_keep[$urandom_range(3)];
                            else fr_keep[i] = 4'($urandom_range(15));
                        end else begin
                            fr_keep[i] = ($urandom_range(19) == 0) ? 4'($urandom_range(15)) : 4'hF;
                        end
                    end
                    send_frame(1'b1);
                end
                drain("drain_rand");
`ifdef STR_NAT_STATS_EN
                chk("stats_frm_final", FRM_CNT, mdl_frames);
                chk("stats_err_final", ERR_CNT, mdl_errs);
`endif
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join_any
    end

endmodule
